bus_arbiter_dual: RTL and testbench
===================================

// Module: bus_arbiter_dual
// PURPOSE
//  Two-master arbiter for the shared system bus. Master 1 is the local demo master; master 2 is the
//  bus-bridge master that serves the remote side. Grants one master at a time using round-robin
//  priority and a one-cycle turnaround. Supports one outstanding slave SPLIT and forces release of a
//  master that holds the bus longer than TIMEOUT cycles.
// PARAMETERS
//  TIMEOUT   1024               max consecutive grant cycles before forced release (>=2)
//  TO_W      $clog2(TIMEOUT+1)  hold-counter width (derived; do not override)
// PORTS
//  clk           in   1     system clock; all logic on posedge
//  rst           in   1     synchronous, active-high reset
//  m1_breq       in   1     master 1 bus request; held high for the whole transaction
//  m2_breq       in   1     master 2 (bridge) bus request; same rule
//  split         in   1     1-cycle pulse from slave: current owner's transaction is split
//  split_done    in   1     1-cycle pulse from slave: split data ready, resume split master
//  m1_grant      out  1     grant to master 1 (registered)
//  m2_grant      out  1     grant to master 2 (registered)
//  msel          out  1     bus mux select: 0 = m1, 1 = m2; holds last owner while idle
//  bus_busy      out  1     high when either grant is high
//  split_pend    out  1     high while a split is outstanding
//  split_owner   out  1     master parked by the split (0 = m1, 1 = m2); valid when split_pend=1
//  timeout_err   out  1     1-cycle pulse on forced release
// BEHAVIOUR
//  - Reset values: all outputs 0, FSM=IDLE, hold counter=0, priority pointer=m1.
//  - FSM states: IDLE, GNT_M1, GNT_M2, TURN.
//  - Eligible request: breq AND NOT (split_pend AND split_owner==that master).
//  - IDLE:
//      - One eligible request: go to its GNT state; grant is high on the next cycle
//        (latency 1 from breq to grant).
//      - Both eligible: grant by priority. Priority order is the split master first just after
//        split_done, otherwise the master other than the last owner.
//  - GNT_x:
//      - Grant held while breq_x=1.
//      - breq_x falls: grant drops next cycle, FSM->TURN, priority pointer moves to the other master.
//  - TURN: exactly one idle cycle with no grant, then ->IDLE. So the minimum gap between two
//    grants is 2 cycles after release.
//  - Hold counter:
//      - Clears on entry to GNT_x and increments each cycle in GNT_x.
//      - Counter reaching TIMEOUT-1 with breq_x still high: grant drops, timeout_err pulses,
//        FSM->TURN. breq_x is then ignored until it has been seen low for at least one cycle.
//  - split in GNT_x (no split pending):
//      - split_pend<=1, split_owner<=x, grant drops next cycle, FSM->TURN.
//      - Master x is masked until split_done.
//  - split while split_pend=1, or split in IDLE/TURN: ignored; no state change.
//  - split_done while split_pend=1: split_pend<=0; that master has top priority at the next IDLE
//    arbitration. split_done with no split pending: ignored.
//  - split and split_done in the same cycle: split_done is processed first, then split. The new
//    owner is parked.
//  - split_done in the same cycle the other master gets a grant: does not preempt; the split master
//    waits for release.
//  - Grants are one-hot or zero in every cycle; never both high.
//  - msel updates in the same cycle as the grant rises and is held through TURN/IDLE.
//  - rst mid-transaction: next cycle both grants=0, split_pend=0, FSM=IDLE.
//    Masters must restart; no recovery of split state.
// STRUCTURE
//  - Shared package bus_pkg:
//      - arb_state_t enum {IDLE, GNT_M1, GNT_M2, TURN}
//      - master-id localparams M1=1'b0, M2=1'b1
//      - DEFAULT_ARB_TIMEOUT=1024
//  - One sub-module: arb_hold_timer.
//      - Inputs: clear, enable.
//      - Output: expired at TIMEOUT-1.
//  - FSM, priority pointer and split tracking stay in the top.
// TESTING
//  - Single request: m1_breq high at cycle 10 for 6 cycles.
//      -> m1_grant high cycles 11..16, low at 17; TURN at 17; msel=0.
//  - Contention: m1 and m2 request together after reset.
//      -> m1 granted first; m1 releases -> m2_grant rises 2 cycles after m1_grant falls.
//      -> Repeat both: m1 and m2 alternate.
//  - Split: m2 granted, split pulse.
//      -> m2_grant drops next cycle, split_pend=1, split_owner=1, m2_breq held but ignored;
//         m1 is granted if requesting.
//      -> split_done -> m2 wins the next arbitration over m1.
//  - Timeout with TIMEOUT=16: m1 holds breq for 40 cycles.
//      -> Grant lasts exactly 16 cycles; timeout_err is a 1-cycle pulse; m1 is not regranted
//         until breq toggles low.
//  - Reset mid-grant: assert rst while m2_grant=1 with split_pend=1.
//      -> Next cycle all outputs 0; after release, a fresh m1 request is granted with latency 1.
//  - Invariant checker for the whole run: never m1_grant & m2_grant;
//    bus_busy == (m1_grant | m2_grant).

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the dual-master system bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M1 = 2'd1,
    GNT_M2 = 2'd2,
    TURN   = 2'd3
  } arb_state_t;

  localparam logic M1 = 1'b0;
  localparam logic M2 = 1'b1;

  localparam int DEFAULT_ARB_TIMEOUT = 1024;

  function automatic arb_state_t gnt_state(input logic id);
    return (id == M2) ? GNT_M2 : GNT_M1;
  endfunction

endpackage

// File: rtl/arb_hold_timer.sv
// Counts consecutive grant cycles; expired is high once the count reaches TIMEOUT-1.
module arb_hold_timer
  import bus_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_ARB_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_d;

  // Next count: clear wins over increment.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + TO_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Hold-counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter_dual.sv
// Two-master round-robin bus arbiter with one-cycle turnaround, single
// outstanding split tracking and forced release after TIMEOUT grant cycles.
module bus_arbiter_dual
  import bus_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_ARB_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic m1_breq,
  input  logic m2_breq,
  input  logic split,
  input  logic split_done,
  output logic m1_grant,
  output logic m2_grant,
  output logic msel,
  output logic bus_busy,
  output logic split_pend,
  output logic split_owner,
  output logic timeout_err
);

  arb_state_t state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       msel_q, msel_d;
  logic       pend_q, pend_d;
  logic       owner_q, owner_d;
  logic       prio_vld_q, prio_vld_d;
  logic       prio_id_q, prio_id_d;
  logic [1:0] lock_q, lock_d;
  logic       to_err_q, to_err_d;
  logic       m1_grant_q, m2_grant_q, busy_q;

  logic [1:0] breq_s;
  logic [1:0] elig_s;
  logic       in_gnt_s;
  logic       cur_s;
  logic       done_s;
  logic       split_ok_s;
  logic       expired_s;
  logic       win_s;

  assign breq_s     = {m2_breq, m1_breq};
  assign elig_s[0]  = m1_breq & ~(pend_q & (owner_q == M1)) & ~lock_q[0];
  assign elig_s[1]  = m2_breq & ~(pend_q & (owner_q == M2)) & ~lock_q[1];
  assign in_gnt_s   = (state_q == GNT_M1) | (state_q == GNT_M2);
  assign cur_s      = (state_q == GNT_M2);
  assign done_s     = split_done & pend_q;
  // A split_done in the same cycle frees the slot before the new split is taken.
  assign split_ok_s = split & in_gnt_s & (~pend_q | split_done);

  arb_hold_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_hold_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (~in_gnt_s),
    .enable_i  (in_gnt_s),
    .expired_o (expired_s)
  );

  // Arbitration winner when leaving IDLE.
  always_comb begin
    win_s = M1;
    if (&elig_s) begin
      win_s = prio_vld_q ? prio_id_q : ptr_q;
    end else begin
      win_s = elig_s[1];
    end
  end

  // Next-state, pointer, split and timeout-lock logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    msel_d     = msel_q;
    pend_d     = pend_q;
    owner_d    = owner_q;
    prio_vld_d = prio_vld_q;
    prio_id_d  = prio_id_q;
    lock_d     = lock_q & breq_s;
    to_err_d   = 1'b0;

    if (done_s) begin
      pend_d     = 1'b0;
      prio_vld_d = 1'b1;
      prio_id_d  = owner_q;
    end else begin
      pend_d = pend_q;
    end

    case (state_q)
      IDLE: begin
        if (elig_s != 2'b00) begin
          state_d    = gnt_state(win_s);
          msel_d     = win_s;
          prio_vld_d = done_s;
        end else begin
          state_d = IDLE;
        end
      end
      GNT_M1, GNT_M2: begin
        if (split_ok_s) begin
          state_d = TURN;
          pend_d  = 1'b1;
          owner_d = cur_s;
          ptr_d   = ~cur_s;
        end else if (!breq_s[cur_s]) begin
          state_d = TURN;
          ptr_d   = ~cur_s;
        end else if (expired_s) begin
          state_d        = TURN;
          to_err_d       = 1'b1;
          lock_d[cur_s]  = 1'b1;
          ptr_d          = ~cur_s;
        end else begin
          state_d = state_q;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= M1;
      msel_q     <= 1'b0;
      pend_q     <= 1'b0;
      owner_q    <= 1'b0;
      prio_vld_q <= 1'b0;
      prio_id_q  <= 1'b0;
      lock_q     <= 2'b00;
      to_err_q   <= 1'b0;
      m1_grant_q <= 1'b0;
      m2_grant_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      msel_q     <= msel_d;
      pend_q     <= pend_d;
      owner_q    <= owner_d;
      prio_vld_q <= prio_vld_d;
      prio_id_q  <= prio_id_d;
      lock_q     <= lock_d;
      to_err_q   <= to_err_d;
      m1_grant_q <= (state_d == GNT_M1);
      m2_grant_q <= (state_d == GNT_M2);
      busy_q     <= (state_d == GNT_M1) | (state_d == GNT_M2);
    end
  end

  assign m1_grant    = m1_grant_q;
  assign m2_grant    = m2_grant_q;
  assign msel        = msel_q;
  assign bus_busy    = busy_q;
  assign split_pend  = pend_q;
  assign split_owner = owner_q;
  assign timeout_err = to_err_q;

endmodule

// File: tb/tb_bus_arbiter_dual.sv
// Scoreboard bench: stimulus pushes expected grant episodes, a monitor pops and checks them.
module tb_bus_arbiter_dual;
  import bus_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst, m1_breq, m2_breq, split, split_done;
  logic m1_grant, m2_grant, msel, bus_busy, split_pend, split_owner, timeout_err;

  bus_arbiter_dual #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .m1_breq     (m1_breq),
    .m2_breq     (m2_breq),
    .split       (split),
    .split_done  (split_done),
    .m1_grant    (m1_grant),
    .m2_grant    (m2_grant),
    .msel        (msel),
    .bus_busy    (bus_busy),
    .split_pend  (split_pend),
    .split_owner (split_owner),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic m;
    int   start;
    int   len;
    logic to;
  } exp_t;

  exp_t sb_q[$];
  bit   mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic go_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic expect_grant(input logic m, input int start, input int len, input logic to);
    exp_t e;
    e = '{m, start, len, to};
    sb_q.push_back(e);
  endtask

  // Monitor: invariants every cycle, grant episodes against the scoreboard.
  initial begin
    exp_t cur;
    logic cur_vld;
    logic prev1, prev2;
    int   rise_cyc;
    cur_vld  = 1'b0;
    prev1    = 1'b0;
    prev2    = 1'b0;
    rise_cyc = 0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        chk("one_hot", {31'd0, m1_grant & m2_grant}, 32'd0);
        chk("bus_busy", {31'd0, bus_busy}, {31'd0, m1_grant | m2_grant});
        if ((m1_grant && !prev1) || (m2_grant && !prev2)) begin
          chk("grant_expected", {31'd0, sb_q.size() != 0}, 32'd1);
          if (sb_q.size() != 0) begin
            cur      = sb_q.pop_front();
            cur_vld  = 1'b1;
            rise_cyc = cyc;
            chk("grant_master", {31'd0, m2_grant}, {31'd0, cur.m});
            chk("grant_start", cyc, cur.start);
            chk("msel", {31'd0, msel}, {31'd0, cur.m});
          end
        end
        if (((!m1_grant && prev1) || (!m2_grant && prev2)) && cur_vld) begin
          chk("grant_len", cyc - rise_cyc, cur.len);
          chk("timeout_err", {31'd0, timeout_err}, {31'd0, cur.to});
          cur_vld = 1'b0;
        end
        prev1 = m1_grant;
        prev2 = m2_grant;
      end
    end
  end

  initial begin
    rst = 1'b1; m1_breq = 1'b0; m2_breq = 1'b0; split = 1'b0; split_done = 1'b0;
    go_to(3);
    chk("rst_m1_grant", {31'd0, m1_grant}, 32'd0);
    chk("rst_m2_grant", {31'd0, m2_grant}, 32'd0);
    chk("rst_msel", {31'd0, msel}, 32'd0);
    chk("rst_busy", {31'd0, bus_busy}, 32'd0);
    chk("rst_split_pend", {31'd0, split_pend}, 32'd0);
    chk("rst_split_owner", {31'd0, split_owner}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    rst = 1'b0;
    mon_on = 1'b1;

    // Single request, then a request during TURN.
    go_to(10); m1_breq = 1'b1; expect_grant(M1, 11, 6, 1'b0);
    go_to(16); m1_breq = 1'b0;
    go_to(17); m1_breq = 1'b1; expect_grant(M1, 19, 2, 1'b0);
    go_to(20); m1_breq = 1'b0;
    go_to(24); rst = 1'b1;
    go_to(25); rst = 1'b0;

    // Contention: alternate between masters.
    go_to(30); m1_breq = 1'b1; m2_breq = 1'b1; expect_grant(M1, 31, 3, 1'b0);
    go_to(33); m1_breq = 1'b0;
    go_to(34); m1_breq = 1'b1; expect_grant(M2, 36, 3, 1'b0);
    go_to(38); m2_breq = 1'b0;
    go_to(39); m2_breq = 1'b1; expect_grant(M1, 41, 3, 1'b0);
    go_to(43); m1_breq = 1'b0; expect_grant(M2, 46, 3, 1'b0);

    // Split of m2; m1 served meanwhile; m2 first after split_done.
    go_to(47); m1_breq = 1'b1;
    go_to(48); split = 1'b1; expect_grant(M1, 51, 5, 1'b0);
    go_to(49); split = 1'b0;
    chk("split_pend_set", {31'd0, split_pend}, 32'd1);
    chk("split_owner_m2", {31'd0, split_owner}, 32'd1);
    go_to(53); split_done = 1'b1;
    go_to(54); split_done = 1'b0;
    chk("split_pend_clr", {31'd0, split_pend}, 32'd0);
    chk("no_preempt", {31'd0, m1_grant}, 32'd1);
    go_to(55); m1_breq = 1'b0; expect_grant(M2, 58, 3, 1'b0);
    go_to(56); m1_breq = 1'b1;
    go_to(60); m2_breq = 1'b0; expect_grant(M1, 63, 2, 1'b0);

    // Split of m1 with pointer on m2: split priority must override the pointer.
    go_to(64); split = 1'b1;
    go_to(65); split = 1'b0;
    chk("split_pend_m1", {31'd0, split_pend}, 32'd1);
    chk("split_owner_m1", {31'd0, split_owner}, 32'd0);
    go_to(68); split_done = 1'b1;
    go_to(69); split_done = 1'b0; m2_breq = 1'b1;
    chk("split_pend_clr2", {31'd0, split_pend}, 32'd0);
    expect_grant(M1, 70, 2, 1'b0);
    go_to(71); m1_breq = 1'b0; m2_breq = 1'b0;

    // Timeout: 16-cycle grant, then locked out until breq drops.
    go_to(80); m1_breq = 1'b1; expect_grant(M1, 81, TO, 1'b1);
    go_to(98); chk("timeout_pulse_width", {31'd0, timeout_err}, 32'd0);
    go_to(110); chk("timeout_lockout", {31'd0, m1_grant}, 32'd0);
    go_to(120); m1_breq = 1'b0;
    go_to(122); m1_breq = 1'b1; expect_grant(M1, 123, 3, 1'b0);
    go_to(125); m1_breq = 1'b0;

    // Reset while m2 granted and a split is pending.
    go_to(130); m1_breq = 1'b1; expect_grant(M1, 131, 2, 1'b0);
    go_to(132); split = 1'b1;
    go_to(133); split = 1'b0; m2_breq = 1'b1; expect_grant(M2, 135, 3, 1'b0);
    go_to(137);
    chk("pre_rst_m2_grant", {31'd0, m2_grant}, 32'd1);
    chk("pre_rst_split_pend", {31'd0, split_pend}, 32'd1);
    rst = 1'b1; m1_breq = 1'b0; m2_breq = 1'b0;
    go_to(138);
    chk("mid_rst_m2_grant", {31'd0, m2_grant}, 32'd0);
    chk("mid_rst_split_pend", {31'd0, split_pend}, 32'd0);
    chk("mid_rst_msel", {31'd0, msel}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus_busy}, 32'd0);
    rst = 1'b0;
    go_to(140); m1_breq = 1'b1; expect_grant(M1, 141, 2, 1'b0);
    go_to(142); m1_breq = 1'b0;

    go_to(150);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
